// File: rtl/stage_memory_access_pkg.sv
// Shared ISA types for the memory-access stage: widths, latency, funct3 codes,
// memory-port control struct and byte-lane helpers.
package stage_memory_access_pkg;

    localparam int XLEN             = 32;
    localparam int mem_read_latency = 3;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wenable;
    } mem_control_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        DONE
    } stage_state_e;

    // Byte-lane write mask for a store of the given width at byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_replicate(input logic [2:0] funct3, input logic [XLEN-1:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/stage_memory_access_if.sv
// Controller <-> memory-access stage bundle, including the memory port.
interface stage_memory_access_if;
    import stage_memory_access_pkg::*;

    logic                 enable;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      store_data;
    logic [XLEN-1:0]      mem_rdata;
    mem_control_t         mem_ctrl;
    logic                 is_complete;
    logic [XLEN-1:0]      load_data;
    logic                 is_halted;

    modport master (
        output enable, is_store, funct3, addr, store_data, mem_rdata,
        input  mem_ctrl, is_complete, load_data, is_halted
    );

    modport slave (
        input  enable, is_store, funct3, addr, store_data, mem_rdata,
        output mem_ctrl, is_complete, load_data, is_halted
    );

endinterface

// File: rtl/stage_memory_access_load_extract.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extract
    import stage_memory_access_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{offset, 3'b000} +: 8];
    assign half_sel = mem_rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            MEM_B:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            MEM_BU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            MEM_H:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            MEM_HU:  value = {{(XLEN-16){1'b0}}, half_sel};
            default: value = mem_rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory_access.sv
// Multi-cycle load/store stage: drives the memory port, waits out read latency,
// extracts load results and halts permanently on misaligned/illegal accesses.
module stage_memory_access
    import stage_memory_access_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    stage_memory_access_if.slave  bus
);

    stage_state_e    state;
    logic [7:0]      remaining;
    logic            halted;
    logic [XLEN-1:0] load_data_q;
    logic [XLEN-1:0] extracted;

    logic funct3_ok;
    logic misaligned;
    logic fault;
    logic go;
    logic load_fire;
    logic store_fire;

    load_extract u_load_extract (
        .mem_rdata (bus.mem_rdata),
        .offset    (bus.addr[1:0]),
        .funct3    (bus.funct3),
        .value     (extracted)
    );

    always_comb begin
        if (bus.is_store)
            funct3_ok = (bus.funct3 == MEM_B) || (bus.funct3 == MEM_H) || (bus.funct3 == MEM_W);
        else
            funct3_ok = (bus.funct3 == MEM_B) || (bus.funct3 == MEM_H) || (bus.funct3 == MEM_W) ||
                        (bus.funct3 == MEM_BU) || (bus.funct3 == MEM_HU);
        misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    end

    assign fault = bus.enable && (!funct3_ok || misaligned);

    // The counter sits at mem_read_latency on the first enabled cycle, so a load
    // finishes on the cycle it holds 1 (or immediately when the latency is 0).
    assign go         = reset && bus.enable && !halted && !fault && (state != DONE);
    assign load_fire  = go && !bus.is_store && (remaining <= 8'd1);
    assign store_fire = go && bus.is_store && (state == IDLE);

    assign bus.is_complete      = load_fire || store_fire;
    assign bus.mem_ctrl.addr    = bus.enable ? {bus.addr[XLEN-1:2], 2'b00} : '0;
    assign bus.mem_ctrl.wdata   = bus.enable ? lane_replicate(bus.funct3, bus.store_data) : '0;
    assign bus.mem_ctrl.wenable = store_fire ? lane_mask(bus.funct3, bus.addr[1:0]) : 4'b0000;
    assign bus.load_data        = load_data_q;
    assign bus.is_halted        = halted;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= 8'(mem_read_latency);
            halted      <= 1'b0;
            load_data_q <= '0;
        end else begin
            if (fault)
                halted <= 1'b1;
            if (!bus.enable) begin
                state     <= IDLE;
                remaining <= 8'(mem_read_latency);
            end else if (bus.is_complete) begin
                state <= DONE;
            end else if (go) begin
                state     <= LOAD_WAIT;
                remaining <= remaining - 8'd1;
            end
            if (load_fire)
                load_data_q <= extracted;
        end
    end

endmodule

// File: tb/tb_stage_memory_access.sv
// Self-checking bench for stage_memory_access: vector table with a scoreboard
// queue, plus hand sequences for abandon, reset and fault behaviour.
module tb_stage_memory_access;
    import stage_memory_access_pkg::*;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] exp_ld;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_we;
    } vec_t;

    typedef struct {
        logic        st;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } exp_t;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
    } fault_t;

    localparam int NV = 12;
    localparam int NF = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] model_ld = '0;
    vec_t   vecs [NV];
    fault_t faults [NF];
    exp_t   sb [$];

    stage_memory_access_if bus ();

    stage_memory_access dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd);
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        bus.mem_rdata  = rd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset      = 1'b0;
        bus.enable = 1'b0;
        next_cycle();
        reset    = 1'b1;
        model_ld = '0;
    endtask

    task automatic run_access(input int i);
        exp_t e;
        exp_t got;
        int   n_done;
        e.st    = vecs[i].st;
        e.cyc   = vecs[i].st ? 1 : ((mem_read_latency < 2) ? 1 : mem_read_latency);
        e.addr  = {vecs[i].addr[31:2], 2'b00};
        e.wdata = vecs[i].exp_wdata;
        e.we    = vecs[i].exp_we;
        sb.push_back(e);
        drive(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sdata, vecs[i].rdata);
        bus.enable = 1'b1;
        n_done = 0;
        for (int c = 1; c <= mem_read_latency + 3; c++) begin
            @(negedge clock);
            if (bus.is_complete) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_complete: got completion at cycle %0d, expected none", c);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d complete_cycle", i), c, got.cyc);
                    chk($sformatf("v%0d mem_addr", i), bus.mem_ctrl.addr, got.addr);
                    chk($sformatf("v%0d wenable", i), {28'd0, bus.mem_ctrl.wenable}, {28'd0, got.we});
                    if (got.st)
                        chk($sformatf("v%0d wdata", i), bus.mem_ctrl.wdata, got.wdata);
                end
            end else begin
                chk($sformatf("v%0d idle_wenable c%0d", i, c), {28'd0, bus.mem_ctrl.wenable}, 32'd0);
            end
            next_cycle();
        end
        chk($sformatf("v%0d completions", i), n_done, 1);
        bus.enable = 1'b0;
        if (!vecs[i].st)
            model_ld = vecs[i].exp_ld;
        @(negedge clock);
        chk($sformatf("v%0d load_data", i), bus.load_data, model_ld);
        chk($sformatf("v%0d halted", i), {31'd0, bus.is_halted}, 32'd0);
        next_cycle();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 4'b0000};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 32'h0, 4'b0000};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 32'h00000080, 32'h0, 4'b0000};
        vecs[3]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 32'h000080FF, 32'h0, 4'b0000};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 32'hFFFF80FF, 32'h0, 4'b0000};
        vecs[5]  = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 32'h00000012, 32'h0, 4'b0000};
        vecs[6]  = '{1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF9234, 32'h00009234, 32'h0, 4'b0000};
        vecs[7]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 32'hABCDABCD, 4'b1100};
        vecs[8]  = '{1'b1, 3'b000, 32'h201, 32'h123456EF, 32'h0, 32'h0, 32'hEFEFEFEF, 4'b0010};
        vecs[9]  = '{1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D, 4'b1111};
        vecs[10] = '{1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 32'h0, 32'hA5A5A5A5, 4'b1000};
        vecs[11] = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, 32'h11223344, 32'h0, 4'b0000};

        faults[0] = '{1'b0, 3'b010, 32'h101};
        faults[1] = '{1'b0, 3'b001, 32'h103};
        faults[2] = '{1'b0, 3'b011, 32'h100};
        faults[3] = '{1'b1, 3'b100, 32'h200};
        faults[4] = '{1'b1, 3'b001, 32'h201};
        faults[5] = '{1'b0, 3'b110, 32'h100};

        // Reset with a word store presented: outputs must stay quiet.
        bus.enable = 1'b1;
        drive(vecs[9].st, vecs[9].f3, vecs[9].addr, vecs[9].sdata, vecs[9].rdata);
        @(negedge clock);
        chk("reset complete", {31'd0, bus.is_complete}, 32'd0);
        chk("reset wenable", {28'd0, bus.mem_ctrl.wenable}, 32'd0);
        next_cycle();
        reset_pulse();
        @(negedge clock);
        chk("reset load_data", bus.load_data, 32'd0);
        chk("reset halted", {31'd0, bus.is_halted}, 32'd0);
        next_cycle();

        for (int i = 0; i < NV; i++)
            run_access(i);

        // Abandon a load one cycle before it would complete.
        drive(vecs[0].st, vecs[0].f3, vecs[0].addr, 32'h0, 32'h55667788);
        bus.enable = 1'b1;
        for (int c = 1; c < mem_read_latency; c++) begin
            @(negedge clock);
            chk($sformatf("abandon complete c%0d", c), {31'd0, bus.is_complete}, 32'd0);
            next_cycle();
        end
        bus.enable = 1'b0;
        @(negedge clock);
        chk("abandon complete_off", {31'd0, bus.is_complete}, 32'd0);
        chk("abandon load_data", bus.load_data, model_ld);
        next_cycle();
        run_access(11);

        // Reset in the middle of a load, then the first scenario again.
        drive(vecs[0].st, vecs[0].f3, vecs[0].addr, 32'h0, vecs[0].rdata);
        bus.enable = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("midreset complete", {31'd0, bus.is_complete}, 32'd0);
        next_cycle();
        reset      = 1'b1;
        bus.enable = 1'b0;
        model_ld   = '0;
        @(negedge clock);
        chk("midreset load_data", bus.load_data, 32'd0);
        chk("midreset halted", {31'd0, bus.is_halted}, 32'd0);
        next_cycle();
        run_access(0);

        // Each fault kind: quiet fault cycle, halted from the next edge.
        for (int f = 0; f < NF; f++) begin
            reset_pulse();
            drive(faults[f].st, faults[f].f3, faults[f].addr, 32'hFFFFFFFF, 32'h80FF1234);
            bus.enable = 1'b1;
            @(negedge clock);
            chk($sformatf("fault%0d pre_halted", f), {31'd0, bus.is_halted}, 32'd0);
            chk($sformatf("fault%0d complete", f), {31'd0, bus.is_complete}, 32'd0);
            chk($sformatf("fault%0d wenable", f), {28'd0, bus.mem_ctrl.wenable}, 32'd0);
            next_cycle();
            @(negedge clock);
            chk($sformatf("fault%0d halted", f), {31'd0, bus.is_halted}, 32'd1);
            next_cycle();
            bus.enable = 1'b0;
            next_cycle();
        end

        // Halt is sticky across enable toggles and ignores later valid accesses.
        drive(vecs[0].st, vecs[0].f3, vecs[0].addr, 32'h0, vecs[0].rdata);
        for (int c = 0; c < 4; c++) begin
            bus.enable = c[0];
            @(negedge clock);
            chk($sformatf("sticky halted c%0d", c), {31'd0, bus.is_halted}, 32'd1);
            next_cycle();
        end
        drive(vecs[9].st, vecs[9].f3, vecs[9].addr, vecs[9].sdata, 32'h0);
        bus.enable = 1'b1;
        @(negedge clock);
        chk("halted store wenable", {28'd0, bus.mem_ctrl.wenable}, 32'd0);
        chk("halted store complete", {31'd0, bus.is_complete}, 32'd0);
        next_cycle();
        bus.enable = 1'b0;
        next_cycle();
        drive(vecs[0].st, vecs[0].f3, vecs[0].addr, 32'h0, vecs[0].rdata);
        bus.enable = 1'b1;
        for (int c = 1; c <= mem_read_latency + 2; c++) begin
            @(negedge clock);
            chk($sformatf("halted load complete c%0d", c), {31'd0, bus.is_complete}, 32'd0);
            next_cycle();
        end
        bus.enable = 1'b0;
        @(negedge clock);
        chk("halted load_data", bus.load_data, model_ld);
        next_cycle();
        reset_pulse();
        @(negedge clock);
        chk("final halted cleared", {31'd0, bus.is_halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_memory_access.md
Name: stage_memory_access

Overview:
- Multi-cycle load/store stage of the hart. It sits downstream of instruction fetch and decode/execute, and upstream of writeback.
- When enabled, it drives the shared memory port for the current LOAD or STORE. For loads, it waits out the memory read latency, then extracts the addressed byte/half/word and sign- or zero-extends it. For stores, it issues byte-lane writes.
- Completion is reported to the hart controller. Misaligned accesses halt the stage permanently, mirroring fetch's halt-on-unknown-opcode.

Parameters:
- None. XLEN, mem_read_latency and mem_control_t come from isa_types.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- enable  input  1  controller holds this high while the stage owns the memory port; a low resets progress.
- is_store  input  1  1 = STORE, 0 = LOAD; sampled while enable is high.
- funct3  input  3  width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- addr  input  XLEN  effective byte address from execute.
- store_data  input  XLEN  rs2 value; low bytes are used.
- mem_rdata  input  XLEN  word read from memory at the aligned address.
- mem_ctrl  output  mem_control_t  fields addr, wdata, wenable[3:0] (byte lanes).
- is_complete  output  1  combinational, high for exactly the final cycle of an access.
- load_data  output  XLEN  registered extended load result; holds until the next load completes.
- is_halted  output  1  sticky misalignment/illegal-funct3 fault.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE, remaining cycles=mem_read_latency.
  - load_data=0, is_halted=0.
  - Outputs during reset: mem_ctrl.wenable=0, is_complete=0.
- Addressing:
  - mem_ctrl.addr = {addr[XLEN-1:2],2'b00} whenever enable=1; 0 otherwise.
  - Byte offset is addr[1:0].
- Fault detection (combinational, only when enable=1):
  - fault if half with addr[0]=1, word with addr[1:0]!=0, or an unlisted funct3 (011, 110, 111; stores with funct3[2]=1).
  - A fault sets is_halted on the next edge. Once halted: is_complete=0 and wenable=0 forever until reset.
  - The fault cycle itself never asserts is_complete or wenable.
- States:
  - IDLE: enable=0. The counter reloads to mem_read_latency.
  - LOAD_WAIT:
    - Entered on the first enabled cycle of a non-faulting load; the counter decrements each enabled cycle.
    - When the counter reaches 0, is_complete=1 that cycle, and load_data latches the extracted value at that edge.
    - The load therefore completes mem_read_latency cycles after enable rises, matching fetch timing.
  - STORE:
    - Single cycle: on the first enabled cycle, wenable is set by lane and is_complete=1.
    - Byte: lane 1<<addr[1:0]. Half: 4'b0011<<addr[1:0]. Word: 4'b1111.
    - wdata = store_data replicated into lanes: byte replicated x4, half x2, word as-is.
  - DONE:
    - After is_complete, if enable stays high, the stage holds with is_complete=0 and wenable=0. There is no double store and no repeated completion.
    - Leaving DONE requires enable=0.
- Extraction:
  - LB/LBU select mem_rdata[8*off +: 8]; LH/LHU select the [16*off[1] +: 16] half.
  - Signed loads sign-extend to XLEN; unsigned loads zero-extend.
- Boundary cases:
  - enable dropped mid-load: abandon the access, reload the counter, leave load_data unchanged.
  - mem_read_latency==0: the load completes on the first enabled cycle.
  - Reset mid-access overrides everything.
  - is_store/funct3/addr changing while enabled is illegal; the stage is not required to track it.

Decomposition:
- Add to isa_types:
  - funct3 load/store enums (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
  - wenable[3:0] and wdata fields in mem_control_t.
- Sub-module load_extract (combinational: mem_rdata, offset, funct3 -> XLEN value) so writeback tests can reuse it.
- Optional: a shared function for lane-mask generation.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, enable held -> is_complete high only on the mem_read_latency-th cycle; load_data=0xDEADBEEF afterwards and held after enable drops.
- LB addr=0x103 with mem_rdata=0x80FF1234 -> load_data=0xFFFFFF80; LBU on the same inputs -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
- SH addr=0x202, store_data=0x0000ABCD -> for one cycle mem_ctrl.addr=0x200, wenable=4'b1100, wdata=0xABCDABCD, is_complete=1; enable held 3 more cycles -> wenable stays 0.
- LW addr=0x101 -> no is_complete, no wenable; is_halted=1 next cycle and stays 1 across enable toggles; a later valid LW is still ignored.
- Load with enable dropped one cycle before completion -> no is_complete, load_data unchanged; re-enable -> full latency observed again.
- reset=0 mid-load, then reset=1 and repeat the first scenario -> identical timing and result, is_halted=0.
